// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 raster generator (40 MHz pixel clock).
// Produces hcount/vcount, positive-polarity hsync/vsync, hblnk/vblnk and a
// frame_start pulse. Every output is registered. The strobes are decoded from
// the next counter values, so they line up with hcount/vcount in the same cycle.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the 16-bit frame_cnt port.

package vga_pkg;
    localparam logic [10:0] HOR_TOTAL_TIME  = 11'd1055;
    localparam logic [10:0] VER_TOTAL_TIME  = 11'd627;
    localparam logic [10:0] HOR_BLANK_START = 11'd799;
    localparam logic [10:0] VER_BLANK_START = 11'd599;
    localparam logic [10:0] HOR_SYNC_START  = 11'd840;
    localparam logic [10:0] HOR_SYNC_END    = 11'd968;
    localparam logic [10:0] VER_SYNC_START  = 11'd601;
    localparam logic [10:0] VER_SYNC_END    = 11'd605;
endpackage

module vga_timing_gen #(
    parameter logic [10:0] H_LAST     = vga_pkg::HOR_TOTAL_TIME,
    parameter logic [10:0] V_LAST     = vga_pkg::VER_TOTAL_TIME,
    parameter logic [10:0] H_BLNK_ST  = vga_pkg::HOR_BLANK_START,
    parameter logic [10:0] V_BLNK_ST  = vga_pkg::VER_BLANK_START,
    parameter logic [10:0] H_SYNC_ST  = vga_pkg::HOR_SYNC_START,
    parameter logic [10:0] H_SYNC_END = vga_pkg::HOR_SYNC_END,
    parameter logic [10:0] V_SYNC_ST  = vga_pkg::VER_SYNC_START,
    parameter logic [10:0] V_SYNC_END = vga_pkg::VER_SYNC_END
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // Timing windows must be ordered blank < sync start < sync end <= last.
    if (!((H_BLNK_ST < H_SYNC_ST) && (H_SYNC_ST < H_SYNC_END) && (H_SYNC_END <= H_LAST)))
    begin : g_bad_h_params
        $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!((V_BLNK_ST < V_SYNC_ST) && (V_SYNC_ST < V_SYNC_END) && (V_SYNC_END <= V_LAST)))
    begin : g_bad_v_params
        $error("vga_timing_gen: illegal vertical timing parameters");
    end

    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        wrap_nxt;
    logic        hsync_nxt;
    logic        vsync_nxt;
    logic        hblnk_nxt;
    logic        vblnk_nxt;

    // Next raster position; holds when en is low, wraps line and frame.
    always_comb begin
        h_nxt    = hcount;
        v_nxt    = vcount;
        wrap_nxt = 1'b0;
        if (en) begin
            if (hcount == H_LAST) begin
                h_nxt = '0;
                if (vcount == V_LAST) begin
                    v_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    v_nxt = vcount + 11'd1;
                end
            end else begin
                h_nxt = hcount + 11'd1;
            end
        end
    end

    // Strobes decoded from the next position so they register alongside it.
    always_comb begin
        hsync_nxt = (h_nxt >= H_SYNC_ST) && (h_nxt < H_SYNC_END);
        vsync_nxt = (v_nxt >= V_SYNC_ST) && (v_nxt < V_SYNC_END);
        hblnk_nxt = (h_nxt > H_BLNK_ST);
        vblnk_nxt = (v_nxt > V_BLNK_ST);
    end

    // Output registers; frame_start only pulses on an enabled wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            hblnk       <= hblnk_nxt;
            vblnk       <= vblnk_nxt;
            frame_start <= wrap_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Frame counter advances on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (wrap_nxt) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-parameter instance for line-level
// timing and a shrunken-raster instance for frame-level timing, both checked
// against a raster-position model (linear pixel index modulo frame size).
// Define VGA_TIMING_FRAME_CNT_EN to also exercise frame_cnt.

module tb_vga_timing_gen;

    localparam int DH_LAST = 1055, DV_LAST = 627, DH_BLNK = 799, DV_BLNK = 599;
    localparam int DH_SS = 840, DH_SE = 968, DV_SS = 601, DV_SE = 605;
    localparam int SH_LAST = 39, SV_LAST = 19, SH_BLNK = 23, SV_BLNK = 14;
    localparam int SH_SS = 27, SH_SE = 31, SV_SS = 16, SV_SE = 18;
    localparam int D_TOT = (DH_LAST + 1) * (DV_LAST + 1);
    localparam int S_TOT = (SH_LAST + 1) * (SV_LAST + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    logic [10:0] hc_d, vc_d, hc_s, vc_s;
    logic        hs_d, vs_d, hb_d, vb_d, fs_d;
    logic        hs_s, vs_s, hb_s, vb_s, fs_s;
    logic [26:0] act_d, act_s;

    int n_cmp = 0;
    int n_fail = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
        .hblnk(hb_d), .vblnk(vb_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_d)
`endif
    );

    vga_timing_gen #(
        .H_LAST(11'd39), .V_LAST(11'd19), .H_BLNK_ST(11'd23), .V_BLNK_ST(11'd14),
        .H_SYNC_ST(11'd27), .H_SYNC_END(11'd31), .V_SYNC_ST(11'd16), .V_SYNC_END(11'd18)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .hblnk(hb_s), .vblnk(vb_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    assign act_d = {hc_d, vc_d, hs_d, vs_d, hb_d, vb_d, fs_d};
    assign act_s = {hc_s, vc_s, hs_s, vs_s, hb_s, vb_s, fs_s};

    // Reference model: linear pixel index within the frame plus pulse flags.
    int pos_d = 0, pos_s = 0, fc_m = 0;
    bit fsm_d = 1'b0, fsm_s = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_d = 0; pos_s = 0; fsm_d = 1'b0; fsm_s = 1'b0; fc_m = 0;
        end else if (en) begin
            pos_d = (pos_d + 1) % D_TOT;
            fsm_d = (pos_d == 0);
            pos_s = (pos_s + 1) % S_TOT;
            fsm_s = (pos_s == 0);
            if (fsm_s) fc_m = (fc_m + 1) % 65536;
        end else begin
            fsm_d = 1'b0;
            fsm_s = 1'b0;
        end
    end

    function automatic logic [26:0] exp_vec(input int pos, input bit fs, input int hl,
                                            input int hb, input int hss, input int hse,
                                            input int vb, input int vss, input int vse);
        int h, v;
        logic [10:0] h11, v11;
        h = pos % (hl + 1);
        v = pos / (hl + 1);
        h11 = h[10:0];
        v11 = v[10:0];
        return {h11, v11, (h >= hss && h < hse), (v >= vss && v < vse), (h > hb), (v > vb), fs};
    endfunction

    function automatic logic [26:0] exp_d();
        return exp_vec(pos_d, fsm_d, DH_LAST, DH_BLNK, DH_SS, DH_SE, DV_BLNK, DV_SS, DV_SE);
    endfunction

    function automatic logic [26:0] exp_s();
        return exp_vec(pos_s, fsm_s, SH_LAST, SH_BLNK, SH_SS, SH_SE, SV_BLNK, SV_SS, SV_SE);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (act_d !== 27'd0) begin
            n_fail++; $display("FAIL reset_d: got %h expected %h", act_d, 27'd0);
        end
        n_cmp++;
        if (act_s !== 27'd0) begin
            n_fail++; $display("FAIL reset_s: got %h expected %h", act_s, 27'd0);
        end
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hc_d !== 11'd1 || vc_d !== 11'd0 || fs_d !== 1'b0) begin
            n_fail++; $display("FAIL release_d: got h=%0d v=%0d fs=%b expected h=1 v=0 fs=0", hc_d, vc_d, fs_d);
        end
        n_cmp++;
        if (act_s !== exp_s()) begin
            n_fail++; $display("FAIL release_s: got %h expected %h", act_s, exp_s());
        end
    endtask

    task automatic test_line_timing();
        int first_hb = -1, hs_cnt = 0, hs_first = -1, hs_last = -1;
        int prev_h = -1;
        bit wrap_seen = 1'b0;
        for (int unsigned i = 0; i < 1100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_d !== exp_d()) begin
                n_fail++; $display("FAIL line_d: got %h expected %h", act_d, exp_d());
            end
            n_cmp++;
            if (act_s !== exp_s()) begin
                n_fail++; $display("FAIL line_s: got %h expected %h", act_s, exp_s());
            end
            if (vc_d == 11'd0 && hb_d && first_hb < 0) first_hb = int'(hc_d);
            if (vc_d == 11'd0 && hs_d) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hc_d);
                hs_last = int'(hc_d);
            end
            if (prev_h == DH_LAST) begin
                wrap_seen = 1'b1;
                n_cmp++;
                if (hc_d !== 11'd0 || vc_d !== 11'd1) begin
                    n_fail++; $display("FAIL line_wrap: got h=%0d v=%0d expected h=0 v=1", hc_d, vc_d);
                end
            end
            prev_h = int'(hc_d);
        end
        n_cmp++;
        if (first_hb != DH_BLNK + 1 || !wrap_seen) begin
            n_fail++; $display("FAIL hblnk_start: got %0d (wrap %b) expected %0d", first_hb, wrap_seen, DH_BLNK + 1);
        end
        n_cmp++;
        if (hs_cnt != DH_SE - DH_SS || hs_first != DH_SS || hs_last != DH_SE - 1) begin
            n_fail++; $display("FAIL hsync_window: got cnt=%0d %0d..%0d expected cnt=%0d %0d..%0d",
                               hs_cnt, hs_first, hs_last, DH_SE - DH_SS, DH_SS, DH_SE - 1);
        end
    endtask

    task automatic test_frame_timing();
        int last_pulse = -1, npulse = 0, vs_cyc = 0, vb_cyc = 0, vs_lo = -1, vs_hi = -1;
        en = 1'b1;
        for (int unsigned i = 0; i < 3 * S_TOT + 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_s !== exp_s()) begin
                n_fail++; $display("FAIL frame_s: got %h expected %h", act_s, exp_s());
            end
            if (npulse == 1) begin
                if (vs_s) begin
                    vs_cyc++;
                    if (vs_lo < 0) vs_lo = int'(vc_s);
                    vs_hi = int'(vc_s);
                end
                if (vb_s) vb_cyc++;
            end
            if (fs_s) begin
                n_cmp++;
                if (hc_s !== 11'd0 || vc_s !== 11'd0) begin
                    n_fail++; $display("FAIL pulse_pos: got h=%0d v=%0d expected 0,0", hc_s, vc_s);
                end
                if (last_pulse >= 0) begin
                    n_cmp++;
                    if (int'(i) - last_pulse != S_TOT) begin
                        n_fail++; $display("FAIL pulse_period: got %0d expected %0d", int'(i) - last_pulse, S_TOT);
                    end
                end
                last_pulse = int'(i);
                npulse++;
            end
        end
        n_cmp++;
        if (npulse < 3) begin
            n_fail++; $display("FAIL pulse_count: got %0d expected at least 3", npulse);
        end
        n_cmp++;
        if (vs_cyc != (SV_SE - SV_SS) * (SH_LAST + 1) || vs_lo != SV_SS || vs_hi != SV_SE - 1) begin
            n_fail++; $display("FAIL vsync_window: got %0d cyc rows %0d..%0d expected %0d cyc rows %0d..%0d",
                               vs_cyc, vs_lo, vs_hi, (SV_SE - SV_SS) * (SH_LAST + 1), SV_SS, SV_SE - 1);
        end
        n_cmp++;
        if (vb_cyc != (SV_LAST - SV_BLNK) * (SH_LAST + 1)) begin
            n_fail++; $display("FAIL vblnk_window: got %0d expected %0d", vb_cyc, (SV_LAST - SV_BLNK) * (SH_LAST + 1));
        end
    endtask

    task automatic test_enable_hold();
        bit found = 1'b0;
        logic [26:0] frozen;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int unsigned i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (hc_d == 11'd839) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL hold_reach: got h=%0d expected 839 within budget", hc_d);
        end
        frozen = act_d;
        en = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act_d !== frozen || hs_d !== 1'b0 || act_d !== exp_d()) begin
                n_fail++; $display("FAIL hold_frozen: got %h expected %h", act_d, frozen);
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hc_d !== 11'd840 || hs_d !== 1'b1) begin
            n_fail++; $display("FAIL hold_resume: got h=%0d hs=%b expected h=840 hs=1", hc_d, hs_d);
        end
        // Hold exactly at the last position of the small frame.
        found = 1'b0;
        for (int unsigned i = 0; i < 2 * S_TOT && !found; i++) begin
            @(negedge clk);
            if (hc_s == 11'(SH_LAST) && vc_s == 11'(SV_LAST)) found = 1'b1;
        end
        en = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!found || fs_s !== 1'b0 || hc_s !== 11'(SH_LAST) || act_s !== exp_s()) begin
                n_fail++; $display("FAIL wrap_hold: got %h found=%b expected %h", act_s, found, exp_s());
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fs_s !== 1'b1 || hc_s !== 11'd0 || vc_s !== 11'd0) begin
            n_fail++; $display("FAIL wrap_resume: got h=%0d v=%0d fs=%b expected 0 0 1", hc_s, vc_s, fs_s);
        end
        @(negedge clk);
        n_cmp++;
        if (fs_s !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width: got fs=%b expected 0", fs_s);
        end
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_cmp++;
            if (act_d !== exp_d()) begin
                n_fail++; $display("FAIL rand_d: got %h expected %h", act_d, exp_d());
            end
            n_cmp++;
            if (act_s !== exp_s()) begin
                n_fail++; $display("FAIL rand_s: got %h expected %h", act_s, exp_s());
            end
        end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        en = 1'b1;
        repeat ($urandom_range(100, 700)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_d !== 27'd0) begin
            n_fail++; $display("FAIL async_d: got %h expected %h", act_d, 27'd0);
        end
        n_cmp++;
        if (act_s !== 27'd0) begin
            n_fail++; $display("FAIL async_s: got %h expected %h", act_s, 27'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned i = 0; i < S_TOT - 1; i++) begin
            @(negedge clk);
            if (fs_s) pulses++;
            n_cmp++;
            if (act_s !== exp_s()) begin
                n_fail++; $display("FAIL post_reset: got %h expected %h", act_s, exp_s());
            end
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL no_early_pulse: got %0d expected 0", pulses);
        end
        @(negedge clk);
        n_cmp++;
        if (fs_s !== 1'b1 || hc_s !== 11'd0 || vc_s !== 11'd0) begin
            n_fail++; $display("FAIL first_wrap: got h=%0d v=%0d fs=%b expected 0 0 1", hc_s, vc_s, fs_s);
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int pulses = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int unsigned i = 0; i < 4 * S_TOT && pulses < 3; i++) begin
            @(negedge clk);
            if (fs_s) pulses++;
        end
        n_cmp++;
        if (fc_s !== 16'd3 || fc_s !== fc_m[15:0]) begin
            n_fail++; $display("FAIL frame_cnt3: got %0d expected 3 (model %0d)", fc_s, fc_m);
        end
        @(negedge clk);
        force dut_s.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_s.frame_cnt;
        pulses = 0;
        for (int unsigned i = 0; i < 2 * S_TOT && pulses < 1; i++) begin
            @(negedge clk);
            if (fs_s) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || fc_s !== 16'h0000) begin
            n_fail++; $display("FAIL frame_cnt_wrap: got %h (pulses %0d) expected 0000", fc_s, pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_enable_hold();
        test_random();
        test_async_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
